// File: rtl/mdu_sequencer.sv
// mdu_sequencer: sequences multi-cycle multiply/divide operations from EXE.
//
// Latches the operands of an accepted MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU,
// drives an external fixed-latency multiplier and an iterative divider through a
// start/done handshake, performs MADD/MSUB accumulation locally and stalls EXE
// until a single-cycle HI/LO write-back.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   op_valid, md_op          instruction present in EXE and its sub-opcode
//   src_a, src_b             forwarded rs/rt operands
//   flush, dis_wr            abort operation / suppress the HI/LO write
//   hi_in, lo_in             current HI/LO (accumulator source)
//   mul_a, mul_b, mul_signed multiplier operands and signedness
//   mul_product              multiplier result (valid MUL_LAT cycles after launch)
//   div_start, div_abort     one-cycle divider control pulses
//   div_signed               signed divide select
//   div_done, div_quot, div_rem  divider completion and results
//   stall, finish            pipeline hold / operation complete
//   hi_we, lo_we, hi_wdata, lo_wdata  HI/LO write-back
//   busy                     sequencer not idle
module mdu_sequencer #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        dis_wr,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    input  logic [63:0] mul_product,
    output logic        div_start,
    output logic        div_abort,
    output logic        div_signed,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        stall,
    output logic        finish,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StAcc,
        StDivStart,
        StDivWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] res_q, res_d;
    logic        zero_q, zero_d;
    // Divider results are captured one cycle before use to keep the divider's
    // output paths off the HI/LO write-back timing path.
    logic        done_q;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;

    logic        is_div_in;
    logic [63:0] acc_base;

    assign is_div_in = (md_op[2:1] == 2'b01);
    assign acc_base  = {hi_in, lo_in};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        zero_d    = zero_q;
        quot_d    = div_done ? div_quot : quot_q;
        rem_d     = div_done ? div_rem : rem_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        finish    = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (op_valid && !flush) begin
                    op_d   = md_op;
                    a_d    = src_a;
                    b_d    = src_b;
                    zero_d = 1'b0;
                    if (is_div_in) begin
                        if (src_b == 32'd0) begin
                            zero_d  = 1'b1;
                            state_d = StDone;
                        end else begin
                            state_d = StDivStart;
                        end
                    end else begin
                        cnt_d   = 4'(MUL_LAT - 1);
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    res_d   = mul_product;
                    state_d = op_q[2] ? StAcc : StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAcc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    // op_q[1] distinguishes MSUB/MSUBU from MADD/MADDU.
                    res_d   = op_q[1] ? (acc_base - res_q) : (acc_base + res_q);
                    state_d = StDone;
                end
            end
            StDivStart: begin
                if (flush) begin
                    div_abort = 1'b1;
                    state_d   = StIdle;
                end else begin
                    div_start = 1'b1;
                    state_d   = StDivWait;
                end
            end
            StDivWait: begin
                if (flush) begin
                    div_abort = 1'b1;
                    state_d   = StIdle;
                end else if (done_q) begin
                    res_d   = {rem_q, quot_q};
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!flush) begin
                    finish = 1'b1;
                    hi_we  = !dis_wr && !zero_q;
                    lo_we  = !dis_wr && !zero_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 64'd0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            done_q  <= div_done;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign stall      = op_valid && !flush && (state_q != StDone);
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    // Gated by busy so the reset value of op_q (MULT) does not show as signed.
    assign mul_signed = busy && ((op_q == 3'd0) || (op_q == 3'd4) || (op_q == 3'd6));
    assign div_signed = busy && (op_q == 3'd2);
    assign hi_wdata   = res_q[63:32];
    assign lo_wdata   = res_q[31:0];

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

    localparam int L = 3;
    localparam int DIV_DONE_K = 33;  // div_start at k=1, done 32 cycles later

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        flush, dis_wr;
    logic [31:0] hi_in, lo_in;
    logic [31:0] mul_a, mul_b;
    logic        mul_signed;
    logic [63:0] mul_product;
    logic        div_start, div_abort, div_signed;
    logic        div_done;
    logic [31:0] div_quot, div_rem;
    logic        stall, finish, hi_we, lo_we, busy;
    logic [31:0] hi_wdata, lo_wdata;

    mdu_sequencer #(.MUL_LAT(L)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .dis_wr(dis_wr),
        .hi_in(hi_in), .lo_in(lo_in), .mul_a(mul_a), .mul_b(mul_b),
        .mul_signed(mul_signed), .mul_product(mul_product),
        .div_start(div_start), .div_abort(div_abort), .div_signed(div_signed),
        .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
        .stall(stall), .finish(finish), .hi_we(hi_we), .lo_we(lo_we),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, set by the stimulus.
    logic        chk_en = 1'b0;
    logic        e_stall = 0, e_fin = 0, e_we = 0, e_busy = 0;
    logic        e_dstart = 0, e_dabort = 0, e_msig = 0, e_dsig = 0;
    logic [31:0] e_a = 0, e_b = 0, e_hi = 0, e_lo = 0;
    logic [31:0] cap_hi, cap_lo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 64'(stall), 64'(e_stall));
            chk("finish", 64'(finish), 64'(e_fin));
            chk("hi_we", 64'(hi_we), 64'(e_we));
            chk("lo_we", 64'(lo_we), 64'(e_we));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("div_start", 64'(div_start), 64'(e_dstart));
            chk("div_abort", 64'(div_abort), 64'(e_dabort));
            chk("mul_signed", 64'(mul_signed), 64'(e_msig));
            chk("div_signed", 64'(div_signed), 64'(e_dsig));
            if (e_busy) begin
                chk("mul_a", 64'(mul_a), 64'(e_a));
                chk("mul_b", 64'(mul_b), 64'(e_b));
            end
            if (e_we) begin
                chk("hi_wdata", 64'(hi_wdata), 64'(e_hi));
                chk("lo_wdata", 64'(lo_wdata), 64'(e_lo));
            end
            if (finish) begin
                cap_hi = hi_wdata;
                cap_lo = lo_wdata;
            end
        end
    end

    // Behavioural model: what HI:LO must hold at the end of an operation.
    function automatic logic [63:0] f_prod(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 3'd0 || op == 3'd4 || op == 3'd6) return 64'(sa * sb);
        return ua * ub;
    endfunction

    function automatic logic [63:0] f_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        int q, r;
        case (op)
            3'd2: begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            3'd3: return {a % b, a / b};
            3'd4, 3'd5: return {hi, lo} + f_prod(op, a, b);
            3'd6, 3'd7: return {hi, lo} - f_prod(op, a, b);
            default: return f_prod(op, a, b);
        endcase
    endfunction

    task automatic set_idle_exp();
        e_stall = 0; e_fin = 0; e_we = 0; e_busy = 0;
        e_dstart = 0; e_dabort = 0; e_msig = 0; e_dsig = 0;
    endtask

    task automatic idle(input int n);
        op_valid = 0; flush = 0; dis_wr = 0; div_done = 0;
        set_idle_exp();
        chk_en = 1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one instruction from its accept cycle (k=0). flush_k<0: no flush.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int flush_k,
                          input bit dis_at_done);
        bit is_div, zero, is_madd, gone;
        int fk, last;
        logic [63:0] res, prod;
        is_div  = (op == 3'd2 || op == 3'd3);
        zero    = is_div && (b == 32'd0);
        is_madd = op[2];
        fk      = zero ? 1 : is_div ? DIV_DONE_K + 2 : is_madd ? L + 2 : L + 1;
        last    = (flush_k >= 0) ? flush_k + 1 : fk;
        res     = zero ? 64'd0 : f_result(op, a, b, hi, lo);
        prod    = f_prod(op, a, b);
        cap_hi  = 32'hx;
        cap_lo  = 32'hx;
        chk_en  = 1;
        for (int k = 0; k <= last; k++) begin
            gone        = (flush_k >= 0) && (k > flush_k);
            op_valid    = !gone;
            md_op       = op;
            src_a       = a;
            src_b       = b;
            hi_in       = hi;
            lo_in       = lo;
            flush       = (k == flush_k);
            dis_wr      = dis_at_done && (k == fk);
            div_done    = is_div && !zero && !gone && (k == DIV_DONE_K);
            div_quot    = div_done ? res[31:0] : 32'hBAD0BAD0;
            div_rem     = div_done ? res[63:32] : 32'hBAD1BAD1;
            mul_product = (!is_div && k == L) ? prod : 64'hDEAD_BEEF_DEAD_BEEF;
            e_busy   = (k >= 1) && !gone && (k <= fk);
            e_stall  = op_valid && !flush && (k < fk);
            e_fin    = (k == fk) && !gone && !flush;
            e_we     = e_fin && !dis_wr && !zero;
            e_dstart = is_div && !zero && (k == 1) && !flush && !gone;
            e_dabort = is_div && !zero && flush && (k >= 1) && (k < fk);
            e_msig   = e_busy && (op == 3'd0 || op == 3'd4 || op == 3'd6);
            e_dsig   = e_busy && (op == 3'd2);
            e_a      = a;
            e_b      = b;
            e_hi     = res[63:32];
            e_lo     = res[31:0];
            @(posedge clk);
            #1;
        end
        set_idle_exp();
    endtask

    initial begin
        rst = 1; op_valid = 0; md_op = 0; src_a = 0; src_b = 0; flush = 0; dis_wr = 0;
        hi_in = 0; lo_in = 0; mul_product = 0; div_done = 0; div_quot = 0; div_rem = 0;
        set_idle_exp();
        chk_en = 1;
        @(negedge clk);
        chk("rst_hi_wdata", 64'(hi_wdata), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        @(posedge clk);
        #1 rst = 0;
        idle(2);

        // MULT -2 * 3
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0, -1, 0);
        chk("mult_hi", 64'(cap_hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(cap_lo), 64'hFFFFFFFA);
        // MULTU back-to-back
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, -1, 0);
        chk("multu_hi", 64'(cap_hi), 64'hFFFFFFFE);
        chk("multu_lo", 64'(cap_lo), 64'h00000001);
        // DIVU 100/7
        run_op(3'd3, 32'd100, 32'd7, 0, 0, -1, 0);
        chk("divu_hi", 64'(cap_hi), 64'd2);
        chk("divu_lo", 64'(cap_lo), 64'd14);
        // DIV -7/2
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, -1, 0);
        chk("div_hi", 64'(cap_hi), 64'hFFFFFFFF);
        chk("div_lo", 64'(cap_lo), 64'hFFFFFFFD);
        // DIV by zero
        run_op(3'd2, 32'd5, 32'd0, 0, 0, -1, 0);
        idle(1);
        // MADDU {0,FFFFFFFF} + 1*1
        run_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, -1, 0);
        chk("maddu_hi", 64'(cap_hi), 64'd1);
        chk("maddu_lo", 64'(cap_lo), 64'd0);
        // MSUB 0 - 1*1
        run_op(3'd6, 32'd1, 32'd1, 32'd0, 32'd0, -1, 0);
        chk("msub_hi", 64'(cap_hi), 64'hFFFFFFFF);
        chk("msub_lo", 64'(cap_lo), 64'hFFFFFFFF);
        // MADD 10 + (-2*3)
        run_op(3'd4, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd10, -1, 0);
        chk("madd_hi", 64'(cap_hi), 64'd0);
        chk("madd_lo", 64'(cap_lo), 64'd4);
        // MSUBU {1,0} - 2*3
        run_op(3'd7, 32'd2, 32'd3, 32'd1, 32'd0, -1, 0);
        chk("msubu_lo", 64'(cap_lo), 64'hFFFFFFFA);

        // flush in 2nd MUL cycle
        run_op(3'd0, 32'd7, 32'd9, 0, 0, 2, 0);
        // flush in DIV_WAIT, then a normal DIVU
        run_op(3'd3, 32'd50, 32'd3, 0, 0, 10, 0);
        run_op(3'd3, 32'd100, 32'd7, 0, 0, -1, 0);
        chk("divu2_lo", 64'(cap_lo), 64'd14);
        // flush coinciding with div_done
        run_op(3'd3, 32'd9, 32'd4, 0, 0, DIV_DONE_K, 0);
        idle(2);
        // flush in DIV_START
        run_op(3'd2, 32'd9, 32'd4, 0, 0, 1, 0);
        // flush in IDLE blocks acceptance
        run_op(3'd1, 32'd3, 32'd3, 0, 0, 0, 0);
        // flush in DONE
        run_op(3'd0, 32'd3, 32'd3, 0, 0, L + 1, 0);
        // flush in ACC
        run_op(3'd4, 32'd3, 32'd3, 0, 0, L + 1, 0);
        // dis_wr during DONE
        run_op(3'd1, 32'd6, 32'd7, 0, 0, -1, 1);
        idle(1);

        // reset mid DIV_WAIT
        chk_en = 0;
        md_op = 3'd3; src_a = 32'd100; src_b = 32'd7; op_valid = 1;
        repeat (8) @(posedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst = 1;
        op_valid = 0;
        #1;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_stall", 64'(stall), 64'd0);
        chk("rstmid_finish", 64'(finish), 64'd0);
        chk("rstmid_div_start", 64'(div_start), 64'd0);
        chk("rstmid_div_signed", 64'(div_signed), 64'd0);
        chk("rstmid_mul_a", 64'(mul_a), 64'd0);
        chk("rstmid_mul_b", 64'(mul_b), 64'd0);
        chk("rstmid_hi_we", 64'(hi_we), 64'd0);
        chk("rstmid_lo_wdata", 64'(lo_wdata), 64'd0);
        @(posedge clk);
        #1 rst = 0;
        idle(3);
        run_op(3'd1, 32'd5, 32'd5, 0, 0, -1, 0);
        chk("post_rst_lo", 64'(cap_lo), 64'd25);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
